// File: rtl/text_term_writer.sv
// Text-terminal writer: ASCII stream in, cursor-tracked writes into the 80x25 screen RAM during display blanking.
// Optional macro TERM_LINE_CLEAR_EN: every row advance blanks the newly entered row.
module text_term_writer #(
    parameter int         COLS      = 80,
    parameter int         ROWS      = 25,
    parameter logic [7:0] BLANK_CHR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  char_i,
    input  logic        char_valid_i,
    output logic        char_ready_o,
    input  logic        ram_grant_i,
    output logic [11:0] ram_addr_o,
    output logic [7:0]  ram_data_o,
    output logic        ram_wren_o,
    output logic [6:0]  cursor_col_o,
    output logic [4:0]  cursor_row_o,
    output logic        busy_o
);

    localparam logic [6:0] COL_MAX = 7'(COLS - 1);
    localparam logic [4:0] ROW_MAX = 5'(ROWS - 1);

`ifdef TERM_LINE_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR, S_LINE_CLR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;
`endif

    state_t      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [4:0]  next_row;
    logic [4:0]  addr_row;
    logic [6:0]  addr_col;

    assign next_row = (row_q == ROW_MAX) ? 5'd0 : row_q + 5'd1;
    assign addr_row = addr_q[11:7];
    assign addr_col = addr_q[6:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= 7'd0;
            row_q   <= 5'd0;
            addr_q  <= 12'd0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (char_valid_i) begin
                    if (char_i == 8'h0D) begin
                        col_d = 7'd0;
                    end else if (char_i == 8'h0A) begin
                        row_d = next_row;
`ifdef TERM_LINE_CLEAR_EN
                        state_d = S_LINE_CLR;
                        addr_d  = {next_row, 7'd0};
                        data_d  = BLANK_CHR;
`endif
                    end else if (char_i == 8'h08) begin
                        if (col_q != 7'd0) begin
                            col_d = col_q - 7'd1;
                        end else if (row_q != 5'd0) begin
                            row_d = row_q - 5'd1;
                            col_d = COL_MAX;
                        end
                    end else if (char_i == 8'h0C) begin
                        state_d = S_CLEAR;
                        addr_d  = 12'd0;
                        data_d  = BLANK_CHR;
                    end else if (char_i >= 8'h20 && char_i != 8'h7F) begin
                        state_d = S_WRITE;
                        addr_d  = {row_q, col_q};
                        data_d  = char_i;
                    end
                end
            end
            S_WRITE: begin
                if (ram_grant_i) begin
                    state_d = S_IDLE;
                    if (col_q == COL_MAX) begin
                        col_d = 7'd0;
                        row_d = next_row;
`ifdef TERM_LINE_CLEAR_EN
                        state_d = S_LINE_CLR;
                        addr_d  = {next_row, 7'd0};
                        data_d  = BLANK_CHR;
`endif
                    end else begin
                        col_d = col_q + 7'd1;
                    end
                end
            end
            S_CLEAR: begin
                if (ram_grant_i) begin
                    if (addr_col == COL_MAX) begin
                        if (addr_row == ROW_MAX) begin
                            state_d = S_IDLE;
                            col_d   = 7'd0;
                            row_d   = 5'd0;
                        end else begin
                            // skip the unused columns 80..127 of each row
                            addr_d = {addr_row + 5'd1, 7'd0};
                        end
                    end else begin
                        addr_d = addr_q + 12'd1;
                    end
                end
            end
`ifdef TERM_LINE_CLEAR_EN
            S_LINE_CLR: begin
                if (ram_grant_i) begin
                    if (addr_col == COL_MAX) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d = addr_q + 12'd1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    assign char_ready_o = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign ram_wren_o   = ram_grant_i & (state_q != S_IDLE);
    assign ram_addr_o   = addr_q;
    assign ram_data_o   = data_q;
    assign cursor_col_o = col_q;
    assign cursor_row_o = row_q;

endmodule

// File: tb/tb_text_term_writer.sv
// Directed bench for text_term_writer: expected RAM writes go into a scoreboard queue, a monitor pops on every write.
module tb_text_term_writer;

`ifdef TERM_LINE_CLEAR_EN
    localparam bit LINE_CLR_EN = 1'b1;
`else
    localparam bit LINE_CLR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_i;
    logic        char_valid_i;
    logic        char_ready_o;
    logic        ram_grant_i;
    logic [11:0] ram_addr_o;
    logic [7:0]  ram_data_o;
    logic        ram_wren_o;
    logic [6:0]  cursor_col_o;
    logic [4:0]  cursor_row_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    logic [11:0] last_addr = 12'd0;
    logic [19:0] sb[$];

    text_term_writer dut (
        .clk         (clk),
        .rst         (rst),
        .char_i      (char_i),
        .char_valid_i(char_valid_i),
        .char_ready_o(char_ready_o),
        .ram_grant_i (ram_grant_i),
        .ram_addr_o  (ram_addr_o),
        .ram_data_o  (ram_data_o),
        .ram_wren_o  (ram_wren_o),
        .cursor_col_o(cursor_col_o),
        .cursor_row_o(cursor_row_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_cursor(input string name, input logic [6:0] col, input logic [4:0] row);
        chk(name, {20'd0, cursor_row_o, cursor_col_o}, {20'd0, row, col});
    endtask

    // Monitor: every granted write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && ram_wren_o) begin
            wr_cnt++;
            last_addr = ram_addr_o;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", ram_addr_o, ram_data_o);
            end else begin
                chk("ram_write", {12'd0, ram_addr_o, ram_data_o}, {12'd0, sb.pop_front()});
            end
        end
    end

    task automatic exp_row_clear(input logic [4:0] r);
        if (LINE_CLR_EN)
            for (int c = 0; c < 80; c++) sb.push_back({r, 7'(c), 8'h20});
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        char_i       = c;
        char_valid_i = 1'b1;
        while (!char_ready_o && n < 10000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!char_ready_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: ready stuck at 0, expected 1");
        end
        @(posedge clk); #1;
        char_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy_o && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic send_lf(input logic [4:0] new_row);
        exp_row_clear(new_row);
        send(8'h0A);
        wait_idle(200);
    endtask

    initial begin
        int w0;
        logic [7:0] ch;
        rst          = 1'b1;
        ram_grant_i  = 1'b1;
        char_i       = 8'h00;
        char_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, char_ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_wren", {31'd0, ram_wren_o}, 32'd0);
        chk("rst_addr_data", {12'd0, ram_addr_o, ram_data_o}, 32'd0);
        chk_cursor("rst_cursor", 7'd0, 5'd0);
        rst = 1'b0;

        // T1: single printable write
        sb.push_back({12'h000, 8'h41});
        send(8'h41);
        chk("t1_wren", {31'd0, ram_wren_o}, 32'd1);
        chk("t1_ready_low", {31'd0, char_ready_o}, 32'd0);
        wait_idle(10);
        chk_cursor("t1_cursor", 7'd1, 5'd0);

        // T2: stalled write holds address/data
        ram_grant_i = 1'b0;
        sb.push_back({12'h001, 8'h42});
        send(8'h42);
        for (int i = 0; i < 5; i++) begin
            chk("t2_wren_low", {31'd0, ram_wren_o}, 32'd0);
            chk("t2_hold", {12'd0, ram_addr_o, ram_data_o}, {12'd0, 12'h001, 8'h42});
            chk("t2_ready_low", {31'd0, char_ready_o}, 32'd0);
            @(posedge clk); #1;
        end
        w0 = wr_cnt;
        ram_grant_i = 1'b1;
        wait_idle(10);
        chk("t2_one_write", wr_cnt - w0, 32'd1);
        chk_cursor("t2_cursor", 7'd2, 5'd0);

        // T3: move to (79,24) and wrap the whole screen
        for (int r = 1; r <= 24; r++) send_lf(5'(r));
        chk_cursor("t3_lf24", 7'd2, 5'd24);
        send(8'h0D);
        send(8'h08);
        chk_cursor("t3_bs_wrap", 7'd79, 5'd23);
        send_lf(5'd24);
        chk_cursor("t3_at_corner", 7'd79, 5'd24);
        sb.push_back({12'hC4F, 8'h5A});
        exp_row_clear(5'd0);
        send(8'h5A);
        wait_idle(200);
        chk_cursor("t3_wrap", 7'd0, 5'd0);

        // T4: control codes
        for (int r = 1; r <= 3; r++) send_lf(5'(r));
        for (int i = 0; i < 10; i++) begin
            ch = (i == 5) ? 8'h80 : (i == 9) ? 8'hFF : 8'(8'h61 + i);
            sb.push_back({5'd3, 7'(i), ch});
            send(ch);
            wait_idle(10);
        end
        chk_cursor("t4_at_10_3", 7'd10, 5'd3);
        w0 = wr_cnt;
        send(8'h01);
        send(8'h7F);
        send(8'h1F);
        chk_cursor("t4_discard", 7'd10, 5'd3);
        send(8'h0D);
        chk("t4_cr_ready", {31'd0, char_ready_o}, 32'd1);
        chk("t4_no_write", wr_cnt - w0, 32'd0);
        chk_cursor("t4_cr", 7'd0, 5'd3);
        send_lf(5'd4);
        chk_cursor("t4_lf", 7'd0, 5'd4);
        send(8'h08);
        chk_cursor("t4_bs_row", 7'd79, 5'd3);

        // T5: form feed with grant toggling
        for (int r = 0; r < 25; r++)
            for (int c = 0; c < 80; c++) sb.push_back({5'(r), 7'(c), 8'h20});
        w0 = wr_cnt;
        send(8'h0C);
        for (int n = 0; n < 8000 && busy_o; n++) begin
            ram_grant_i = ~ram_grant_i;
            @(posedge clk); #1;
        end
        ram_grant_i = 1'b1;
        chk("t5_done", {31'd0, busy_o}, 32'd0);
        chk("t5_writes", wr_cnt - w0, 32'd2000);
        chk("t5_last_addr", {20'd0, last_addr}, 32'hC4F);
        chk_cursor("t5_cursor", 7'd0, 5'd0);
        chk("t5_ready", {31'd0, char_ready_o}, 32'd1);

        sb.push_back({12'h000, 8'h71});
        send(8'h71);
        wait_idle(10);
        send(8'h08);
        chk_cursor("t4_bs_col", 7'd0, 5'd0);
        send(8'h08);
        chk_cursor("t4_bs_origin", 7'd0, 5'd0);

        // T6: reset in the middle of a clear
        for (int r = 0; r < 25; r++)
            for (int c = 0; c < 80; c++) sb.push_back({5'(r), 7'(c), 8'h20});
        send(8'h0C);
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_wren", {31'd0, ram_wren_o}, 32'd0);
        chk("t6_busy", {31'd0, busy_o}, 32'd0);
        chk_cursor("t6_cursor", 7'd0, 5'd0);
        rst = 1'b0;
        sb.delete();
        w0 = wr_cnt;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_writes", wr_cnt - w0, 32'd0);
        send_lf(5'd1);
        chk("t6_lf_writes", wr_cnt - w0, LINE_CLR_EN ? 32'd80 : 32'd0);
        chk_cursor("t6_lf_cursor", 7'd0, 5'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
